player_motion: RTL
==================

# player_motion

Vertical motion integrator for the player sprite. It sits between gravity-direction control and rendering/collision. Once per frame-rate move tick it advances the player's height in the current gravity direction. It snaps the player onto line surfaces and flags death on leaving the playfield. The `height` and `grounded` it produces are fed back into the gravity-direction block.

## Interface
Parameters:
- `TICK_DIV`, default 416667: clk cycles per move tick (240 Hz at 100 MHz).
- `VMAX`, default 8: maximum speed, in height units per tick.
- `H_START`, default 120: height after reset or restart.
- `H_MAX`, default 479: ceiling; reaching it is death.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-low.
- `restart`, in, 1: synchronous pulse; return to start state.
- `dir`, in, 1: 0 = gravity toward lower height, 1 = toward higher height.
- `lines`, in, 3: line-present flags for the current column.
- `height`, out, 9: player altitude, unsigned, 0 = bottom.
- `grounded`, out, 1: resting on a surface.
- `dead`, out, 1: player left the playfield.
- `move_tick`, out, 1: one-cycle pulse marking each update.

## Operation
- Rest targets:
  - `dir`=0: 240 if `lines[1]`, 120 if `lines[0]`.
  - `dir`=1: 180 if `lines[1]`, 300 if `lines[2]`.
- States: AIR, GROUND, DEAD. Registers: `height`, `vel` (4 bits, 0..VMAX), `dir_q`.
- On `move_tick` in AIR:
  - `vel_n` = min(`vel`+1, VMAX).
  - `new` = `height` − `vel_n` (`dir`=0) or `height` + `vel_n` (`dir`=1), computed 11-bit signed.
  - Landing when a target T satisfies `height` ≥ T ≥ `new` (`dir`=0) or `height` ≤ T ≤ `new` (`dir`=1), inclusive.
  - If several targets satisfy the test, the first one encountered wins: 240 before 120, or 180 before 300.
  - On landing: `height`←T, `vel`←0, go to GROUND.
  - Else if `new` ≤ 0 (`dir`=0): `height`←0, go to DEAD.
  - Else if `new` ≥ H_MAX (`dir`=1): `height`←H_MAX, go to DEAD.
  - Else `height`←`new`, `vel`←`vel_n`.
  - Landing is checked before death.
- On `move_tick` in GROUND:
  - Stay if `dir`==`dir_q` and the current height is still an active target for `dir`.
  - Otherwise go to AIR with `vel`=0. The motion step is applied on this same tick, using `vel_n`=1.
- A `dir` change observed while in AIR resets `vel` to 0 before the step; `vel_n` becomes 1.
- `dir_q` updates on every `move_tick`.
- DEAD: `height`, `vel` and `dir_q` are frozen. Only `restart` or `reset` leaves DEAD.
- `restart`: `height`←H_START, `vel`←0, AIR, divider cleared. It has priority over a coincident tick.
- `grounded` = (state==GROUND). `dead` = (state==DEAD).

## Timing
- Reset values: `height`=H_START, `vel`=0, AIR, `grounded`=0, `dead`=0, `move_tick`=0, `dir_q`=0, divider=0.
- The divider counts 0..TICK_DIV−1. `move_tick` is high for the one cycle where count == TICK_DIV−1.
- The update is evaluated in the `move_tick` cycle. Registered results appear the next cycle: one-cycle latency.
- `dir` and `lines` are sampled only in the `move_tick` cycle.
- Reset is asynchronous mid-flight: all registers go to reset values immediately.

## Configuration
- `PLAYER_ACCEL_EN` defined: velocity ramps by 1 per tick up to VMAX, as described above.
- Not defined: `vel_n` = VMAX always, giving constant speed. The `vel` register is still present, fixed at VMAX when airborne.

## Structure
- Shared package holds the following, shared with gravity direction and the renderer:
  - state enum.
  - line heights 120/180/240/300.
  - height width 9.
- One sub-module, `tick_gen`: parameterised divider producing `move_tick`, with synchronous clear.

## Test plan
Parameters for all scenarios: TICK_DIV=4, VMAX=8, H_START=120.
1. Reset, `lines`=001, `dir`=0, first tick -> `grounded`=1, `height`=120, and it holds on later ticks.
2. Grounded at 120, set `dir`=1, `lines`=010 -> heights 121,123,126,130,135,141,148,156,164,172, then 180 with `grounded`=1 on the 11th tick.
3. At 180, set `dir`=0, `lines`=001 -> heights 179,177,174,170,165,159,152,144,136,128, then 120 `grounded`.
4. At 120, `lines`=000, `dir`=0 -> player falls; `height`=0, `dead`=1, frozen across 5 ticks. Then `restart` -> `height`=120, `dead`=0.
5. Build without `PLAYER_ACCEL_EN`, from 120, `dir`=1, `lines`=010 -> heights 128..176 in steps of 8, then snap to 180 on the 8th tick, not 184.
6. Assert `reset` while airborne at height 150 -> same cycle `height`=120, `grounded`=0, `dead`=0, `move_tick` divider restarts.

Source files
------------

// File: rtl/player_motion_pkg.sv
// Shared definitions for the player motion path: state encoding, line heights, height width.
package player_motion_pkg;

   localparam int HEIGHT_W = 9;

   typedef enum logic [1:0] {
      AIR    = 2'd0,
      GROUND = 2'd1,
      DEAD   = 2'd2
   } motion_state_e;

   localparam logic [HEIGHT_W-1:0] LINE_H0 = 9'd120;
   localparam logic [HEIGHT_W-1:0] LINE_H1 = 9'd180;
   localparam logic [HEIGHT_W-1:0] LINE_H2 = 9'd240;
   localparam logic [HEIGHT_W-1:0] LINE_H3 = 9'd300;

   // Widen an unsigned height so it can be compared against signed step results.
   function automatic logic signed [10:0] toSigned(input logic [HEIGHT_W-1:0] h);
      return $signed({2'b00, h});
   endfunction

   function automatic logic between(input logic signed [10:0] lo,
                                    input logic signed [10:0] t,
                                    input logic signed [10:0] hi);
      return (lo <= t) && (t <= hi);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle pulse every TICK_DIV clocks, with synchronous clear.
module tick_gen #(
   parameter int TICK_DIV = 416667
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   output logic tick_o
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q + 1'b1;
      if (clear_i || count_q == LAST) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick_o = (count_q == LAST);

endmodule

// File: rtl/player_motion.sv
// Vertical motion integrator for the player sprite; define PLAYER_ACCEL_EN for ramped
// velocity, otherwise the player moves at constant VMAX speed while airborne.
module player_motion
   import player_motion_pkg::*;
#(
   parameter int TICK_DIV = 416667,
   parameter int VMAX     = 8,
   parameter int H_START  = 120,
   parameter int H_MAX    = 479
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                restart,
   input  logic                dir,
   input  logic [2:0]          lines,
   output logic [HEIGHT_W-1:0] height,
   output logic                grounded,
   output logic                dead,
   output logic                move_tick
);

   localparam logic [3:0]          VMAX_V   = 4'(VMAX);
   localparam logic [HEIGHT_W-1:0] HSTART_V = HEIGHT_W'(H_START);
   localparam logic [HEIGHT_W-1:0] HMAX_V   = HEIGHT_W'(H_MAX);
   localparam logic signed [10:0]  HMAX_S   = 11'(H_MAX);

   motion_state_e       state_q, state_d;
   logic [HEIGHT_W-1:0] height_q, height_d;
   logic [3:0]          vel_q, vel_d;
   logic                dir_q, dir_d;

   logic                velReset;
   logic                doStep;
   logic                restAtHeight;
   logic [3:0]          velN;
   logic signed [10:0]  hS, newS;

   tick_gen #(.TICK_DIV(TICK_DIV)) uTickGen (
      .clk     (clk),
      .reset   (reset),
      .clear_i (restart),
      .tick_o  (move_tick)
   );

   // Next-state: restart beats the tick; otherwise one motion step per tick unless resting or dead.
   always_comb begin
      state_d      = state_q;
      height_d     = height_q;
      vel_d        = vel_q;
      dir_d        = dir_q;
      velReset     = 1'b0;
      doStep       = 1'b0;
      velN         = '0;
      newS         = '0;
      hS           = toSigned(height_q);
      restAtHeight = dir ? ((lines[1] && height_q == LINE_H1) || (lines[2] && height_q == LINE_H3))
                         : ((lines[1] && height_q == LINE_H2) || (lines[0] && height_q == LINE_H0));

      if (restart) begin
         state_d  = AIR;
         height_d = HSTART_V;
         vel_d    = '0;
      end else if (move_tick && state_q != DEAD) begin
         dir_d = dir;
         case (state_q)
            AIR: begin
               doStep   = 1'b1;
               velReset = (dir != dir_q);
            end
            GROUND: begin
               if (!(dir == dir_q && restAtHeight)) begin
                  doStep   = 1'b1;
                  velReset = 1'b1;
               end
            end
            default: ;
         endcase

         if (doStep) begin
`ifdef PLAYER_ACCEL_EN
            if (velReset) begin
               velN = 4'd1;
            end else if (vel_q >= VMAX_V) begin
               velN = VMAX_V;
            end else begin
               velN = vel_q + 4'd1;
            end
`else
            velN = (velReset || vel_q == '0) ? VMAX_V : vel_q;
`endif
            newS = dir ? (hS + $signed({7'd0, velN})) : (hS - $signed({7'd0, velN}));

            // Targets are tried in the order the player meets them.
            if (!dir && lines[1] && between(newS, toSigned(LINE_H2), hS)) begin
               state_d  = GROUND;
               height_d = LINE_H2;
               vel_d    = '0;
            end else if (!dir && lines[0] && between(newS, toSigned(LINE_H0), hS)) begin
               state_d  = GROUND;
               height_d = LINE_H0;
               vel_d    = '0;
            end else if (dir && lines[1] && between(hS, toSigned(LINE_H1), newS)) begin
               state_d  = GROUND;
               height_d = LINE_H1;
               vel_d    = '0;
            end else if (dir && lines[2] && between(hS, toSigned(LINE_H3), newS)) begin
               state_d  = GROUND;
               height_d = LINE_H3;
               vel_d    = '0;
            end else if (!dir && newS <= 0) begin
               state_d  = DEAD;
               height_d = '0;
            end else if (dir && newS >= HMAX_S) begin
               state_d  = DEAD;
               height_d = HMAX_V;
            end else begin
               state_d  = AIR;
               height_d = newS[HEIGHT_W-1:0];
               vel_d    = velN;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= AIR;
         height_q <= HSTART_V;
         vel_q    <= '0;
         dir_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         height_q <= height_d;
         vel_q    <= vel_d;
         dir_q    <= dir_d;
      end
   end

   assign height   = height_q;
   assign grounded = (state_q == GROUND);
   assign dead     = (state_q == DEAD);

endmodule
